// File: rtl/alu_pkg.sv
// alu_pkg -- shared opcode map and operand-class decode for the ALU issue path.
// Contents: opcode localparams (ADD_OP=0 .. LUI_OP=19), op_class_t enum, and
// op_class() which classifies a 5-bit opcode as reg-reg, reg-imm, lui or illegal.
package alu_pkg;

    localparam logic [4:0] ADD_OP   = 5'd0;
    localparam logic [4:0] SUB_OP   = 5'd1;
    localparam logic [4:0] AND_OP   = 5'd2;
    localparam logic [4:0] OR_OP    = 5'd3;
    localparam logic [4:0] XOR_OP   = 5'd4;
    localparam logic [4:0] SLL_OP   = 5'd5;
    localparam logic [4:0] SRL_OP   = 5'd6;
    localparam logic [4:0] SRA_OP   = 5'd7;
    localparam logic [4:0] SLT_OP   = 5'd8;
    localparam logic [4:0] SLTU_OP  = 5'd9;
    localparam logic [4:0] ADDI_OP  = 5'd10;
    localparam logic [4:0] ANDI_OP  = 5'd11;
    localparam logic [4:0] ORI_OP   = 5'd12;
    localparam logic [4:0] XORI_OP  = 5'd13;
    localparam logic [4:0] SLLI_OP  = 5'd14;
    localparam logic [4:0] SRLI_OP  = 5'd15;
    localparam logic [4:0] SRAI_OP  = 5'd16;
    localparam logic [4:0] SLTI_OP  = 5'd17;
    localparam logic [4:0] SLTIU_OP = 5'd18;
    localparam logic [4:0] LUI_OP   = 5'd19;

    typedef enum logic [1:0] {
        CLS_RR  = 2'd0,   // a = R[rs1], b = R[rs2]
        CLS_RI  = 2'd1,   // a = R[rs1], b = imm
        CLS_LUI = 2'd2,   // a = 0,      b = imm
        CLS_ILL = 2'd3    // a = 0,      b = 0
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        if (op <= SLTU_OP)       return CLS_RR;
        else if (op <= SLTIU_OP) return CLS_RI;
        else if (op == LUI_OP)   return CLS_LUI;
        else                     return CLS_ILL;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile -- NREGS x 32 register file, x0 hardwired to zero.
// Ports: clk, rst (async, active-high, clears all entries);
//        we/waddr/wdata  synchronous write port (writes to x0 dropped);
//        raddr_a/rdata_a, raddr_b/rdata_b  combinational operand reads;
//        dbg_addr/dbg_data  combinational debug read.
module alu_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] r_mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Entry 0 is never written, but reads are forced to zero anyway so x0
    // cannot leak a value through any port.
    assign rdata_a  = (raddr_a  == '0) ? '0 : r_mem[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : r_mem[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- single-issue operand fetch, EX register and writeback
// for an external combinational ALU.
// Ports: clk, rst (async active-high);
//        in_valid/in_ready handshake with in_opcode/in_rd/in_rs1/in_rs2/in_imm;
//        operand_a/operand_b/opcode to the ALU, alu_result back from it;
//        wb_valid/wb_rd/wb_data retirement observation;
//        dbg_addr/dbg_data combinational register-file read.
// Build option: define ALU_FWD_EN to forward alu_result over a RAW hazard
// against the EX instruction instead of stalling one cycle.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [4:0]  opcode,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    op_class_t   w_cls;
    logic        w_uses_rs1, w_uses_rs2;
    logic        w_haz_a, w_haz_b, w_hazard;
    logic        w_accept;
    logic [31:0] w_rs1_data, w_rs2_data;
    logic [31:0] w_src_a, w_src_b;
    logic [31:0] w_op_a, w_op_b;

    logic        r_ex_valid;
    logic [4:0]  r_ex_op;
    logic [4:0]  r_ex_rd;
    logic [31:0] r_ex_a, r_ex_b;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (r_ex_valid),
        .waddr    (r_ex_rd),
        .wdata    (alu_result),
        .raddr_a  (in_rs1),
        .rdata_a  (w_rs1_data),
        .raddr_b  (in_rs2),
        .rdata_b  (w_rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign w_cls      = op_class(in_opcode);
    assign w_uses_rs1 = (w_cls == CLS_RR) || (w_cls == CLS_RI);
    assign w_uses_rs2 = (w_cls == CLS_RR);

    // Hazard is qualified by in_valid so idle-cycle field garbage never
    // pulls in_ready low.
    assign w_haz_a  = in_valid && r_ex_valid && (r_ex_rd != '0) && w_uses_rs1 && (r_ex_rd == in_rs1);
    assign w_haz_b  = in_valid && r_ex_valid && (r_ex_rd != '0) && w_uses_rs2 && (r_ex_rd == in_rs2);
    assign w_hazard = w_haz_a || w_haz_b;

`ifdef ALU_FWD_EN
    assign in_ready = !rst;
    assign w_src_a  = w_haz_a ? alu_result : w_rs1_data;
    assign w_src_b  = w_haz_b ? alu_result : w_rs2_data;
`else
    assign in_ready = !rst && !w_hazard;
    assign w_src_a  = w_rs1_data;
    assign w_src_b  = w_rs2_data;
`endif

    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (w_cls)
            CLS_RR:  begin w_op_a = w_src_a; w_op_b = w_src_b; end
            CLS_RI:  begin w_op_a = w_src_a; w_op_b = in_imm;  end
            CLS_LUI: begin w_op_a = '0;      w_op_b = in_imm;  end
            default: begin w_op_a = '0;      w_op_b = '0;      end
        endcase
    end

    // EX registers are cleared on non-accept edges so the ALU-facing
    // outputs read zero whenever the stage is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else begin
            r_ex_valid <= w_accept;
            r_ex_op    <= w_accept ? in_opcode : '0;
            r_ex_rd    <= w_accept ? in_rd     : '0;
            r_ex_a     <= w_accept ? w_op_a    : '0;
            r_ex_b     <= w_accept ? w_op_b    : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= r_ex_valid;
            if (r_ex_valid) begin
                r_wb_rd   <= r_ex_rd;
                r_wb_data <= alu_result;
            end
        end
    end

    assign operand_a = r_ex_a;
    assign operand_b = r_ex_b;
    assign opcode    = r_ex_op;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage -- scoreboard bench for alu_issue_stage with a
// behavioural ALU closing the alu_result loop.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode, in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  opcode;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;
    wb_exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.NREGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .opcode     (opcode),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Environment ALU; unknown opcodes produce 0.
    always_comb begin
        alu_result = '0;
        case (opcode)
            5'd0, 5'd10:  alu_result = operand_a + operand_b;
            5'd1:         alu_result = operand_a - operand_b;
            5'd2, 5'd11:  alu_result = operand_a & operand_b;
            5'd3, 5'd12:  alu_result = operand_a | operand_b;
            5'd4, 5'd13:  alu_result = operand_a ^ operand_b;
            5'd5, 5'd14:  alu_result = operand_a << operand_b[4:0];
            5'd6, 5'd15:  alu_result = operand_a >> operand_b[4:0];
            5'd7, 5'd16:  alu_result = $unsigned($signed(operand_a) >>> operand_b[4:0]);
            5'd8, 5'd17:  alu_result = {31'd0, $signed(operand_a) < $signed(operand_b)};
            5'd9, 5'd18:  alu_result = {31'd0, operand_a < operand_b};
            5'd19:        alu_result = operand_b << 12;
            default:      alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wb_exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every retirement must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                check("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_dbg(input logic [4:0] a, input logic [31:0] expv);
        dbg_addr = a;
        #1;
        check($sformatf("dbg_x%0d", a), dbg_data, expv);
    endtask

    // Presents one instruction and returns #1 after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, output int stalls);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        stalls    = 0;
        @(negedge clk);
        while (!in_ready && stalls < 8) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("ready_in_reset", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
    endtask

    int st;
    int exp_stall;

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        dbg_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_operand_a", operand_a, 32'd0);
        check("rst_operand_b", operand_b, 32'd0);
        check("rst_opcode", {27'd0, opcode}, 32'd0);
        chk_dbg(5'd1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // ADDI x1 = x0 + 5
        push(5'd1, 32'd5);
        issue(5'd10, 5'd1, 5'd0, 5'd0, 32'd5, st);
        check("addi_operand_b", operand_b, 32'd5);
        check("addi_opcode", {27'd0, opcode}, 32'd10);
        idle(1);
        check("addi_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk_dbg(5'd1, 32'd5);
        idle(1);
        check("wb_valid_drops", {31'd0, wb_valid}, 32'd0);

        // Back-to-back RAW from cleared state: ADDI x1=5; ADD x2=x1+x1
        do_reset();
        push(5'd1, 32'd5);
        push(5'd2, 32'd10);
        issue(5'd10, 5'd1, 5'd0, 5'd0, 32'd5, st);
        issue(5'd0, 5'd2, 5'd1, 5'd1, 32'd0, st);
`ifdef ALU_FWD_EN
        exp_stall = 0;
`else
        exp_stall = 1;
`endif
        check("raw_stall_cycles", st, exp_stall);
        idle(2);
        chk_dbg(5'd2, 32'd10);

        // LUI x3, 0xABC
        push(5'd3, 32'h00AB_C000);
        issue(5'd19, 5'd3, 5'd7, 5'd7, 32'h0000_0ABC, st);
        check("lui_operand_a", operand_a, 32'd0);
        check("lui_operand_b", operand_b, 32'h0000_0ABC);
        check("lui_opcode", {27'd0, opcode}, 32'd19);
        idle(2);
        chk_dbg(5'd3, 32'h00AB_C000);

        // ADDI x0 = 7 retires but writes nothing; following ADD rs1=x0 does not stall
        push(5'd0, 32'd7);
        issue(5'd10, 5'd0, 5'd0, 5'd0, 32'd7, st);
        push(5'd7, 32'd5);
        issue(5'd0, 5'd7, 5'd0, 5'd1, 32'd0, st);
        check("x0_no_stall", st, 0);
        idle(2);
        chk_dbg(5'd0, 32'd0);
        chk_dbg(5'd7, 32'd5);

        // rs2 field of a reg-imm op is not a dependency; SUB with rs2 RAW is
        push(5'd8, 32'd20);
        issue(5'd10, 5'd8, 5'd0, 5'd0, 32'd20, st);
        push(5'd9, 32'h1F);
        issue(5'd12, 5'd9, 5'd0, 5'd8, 32'h1F, st);
        check("ri_rs2_no_stall", st, 0);
        push(5'd10, 32'hFFFF_FFF5);
        issue(5'd1, 5'd10, 5'd8, 5'd9, 32'd0, st);
        check("rs2_raw_stall", st, exp_stall);
        idle(2);
        chk_dbg(5'd10, 32'hFFFF_FFF5);

        // Illegal opcode 25 zeroes operands and overwrites x5 with 0
        push(5'd5, 32'h55);
        issue(5'd10, 5'd5, 5'd0, 5'd0, 32'h55, st);
        idle(2);
        chk_dbg(5'd5, 32'h55);
        push(5'd5, 32'd0);
        issue(5'd25, 5'd5, 5'd1, 5'd2, 32'h123, st);
        check("ill_operand_a", operand_a, 32'd0);
        check("ill_operand_b", operand_b, 32'd0);
        check("ill_opcode", {27'd0, opcode}, 32'd25);
        idle(2);
        chk_dbg(5'd5, 32'd0);

        // Reset while ADDI x4=9 sits in EX: nothing retires or writes
        idle(2);
        issue(5'd10, 5'd4, 5'd0, 5'd0, 32'd9, st);
        rst = 1'b1;
        #1;
        check("midrst_operand_b", operand_b, 32'd0);
        check("midrst_opcode", {27'd0, opcode}, 32'd0);
        check("midrst_operand_a", operand_a, 32'd0);
        @(negedge clk);
        check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        rst = 1'b0;
        idle(2);
        chk_dbg(5'd4, 32'd0);
        chk_dbg(5'd1, 32'd0);
        check("midrst_wb_idle", {31'd0, wb_valid}, 32'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
